stopwatch_ctrl: RTL

Run-control and display-sequencing controller for the stopwatch. It turns the debounced start/stop/split pulses into the `running` enable for the time counter and a one-cycle counter clear. It also keeps a split (lap) capture register and a lap count, and chooses whether the seven-segment driver shows the live time or the frozen lap time. It sits between the button block and the time counter / BCD_SSEG display path, replacing ad-hoc run logic at top level.

---
 rtl/stopwatch_pkg.sv | 56 +++++
 rtl/split_latch.sv | 51 +++++
 rtl/stopwatch_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run-control block.
// Optional feature macro: STOPWATCH_HR_PAGE_EN (hr:min display page).
package stopwatch_pkg;

  localparam int unsigned BCD_W    = 4;
  localparam int unsigned TIME_W   = 24;
  localparam int unsigned DISP_W   = 4 * BCD_W;
  localparam int unsigned LAP_W    = 4;

  // Display field offsets within the 24-bit BCD time word
  localparam int unsigned MMSS_LSB = 0;
  localparam int unsigned HHMM_LSB = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StSplit  = 2'd2,
    StPaused = 2'd3
  } sw_state_e;

  // The single button event that acts in a cycle
  typedef enum logic [1:0] {
    EvNone  = 2'd0,
    EvStop  = 2'd1,
    EvStart = 2'd2,
    EvSplit = 2'd3
  } sw_event_e;

  // stop beats start beats split; lower-priority pulses are dropped
  function automatic sw_event_e pick_event(input logic stop, input logic start,
                                           input logic split);
    sw_event_e ev;
    if (stop) begin
      ev = EvStop;
    end else if (start) begin
      ev = EvStart;
    end else if (split) begin
      ev = EvSplit;
    end else begin
      ev = EvNone;
    end
    return ev;
  endfunction

  function automatic logic [LAP_W-1:0] lap_sat_inc(input logic [LAP_W-1:0] cnt,
                                                   input logic [LAP_W-1:0] cnt_max);
    logic [LAP_W-1:0] nxt;
    if (cnt >= cnt_max) begin
      nxt = cnt_max;
    end else begin
      nxt = cnt + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/split_latch.sv
// Lap capture register and saturating lap counter.
// Clear wins over capture; the controller never asserts both together.
module split_latch
  import stopwatch_pkg::*;
#(
  parameter int unsigned LAP_MAX = 9
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_capture,
  input  logic              i_clear,
  input  logic [TIME_W-1:0] i_time,
  output logic [TIME_W-1:0] o_lap_time,
  output logic [LAP_W-1:0]  o_lap_cnt
);

  localparam logic [LAP_W-1:0] LapMax = LAP_W'(LAP_MAX);

  logic [TIME_W-1:0] r_lap_time;
  logic [TIME_W-1:0] w_lap_time_d;
  logic [LAP_W-1:0]  r_lap_cnt;
  logic [LAP_W-1:0]  w_lap_cnt_d;

  // Next-state for the lap word and count
  always_comb begin
    w_lap_time_d = r_lap_time;
    w_lap_cnt_d  = r_lap_cnt;
    if (i_clear) begin
      w_lap_time_d = '0;
      w_lap_cnt_d  = '0;
    end else if (i_capture) begin
      w_lap_time_d = i_time;
      w_lap_cnt_d  = lap_sat_inc(r_lap_cnt, LapMax);
    end
  end

  // Lap storage with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lap_time <= '0;
      r_lap_cnt  <= '0;
    end else begin
      r_lap_time <= w_lap_time_d;
      r_lap_cnt  <= w_lap_cnt_d;
    end
  end

  assign o_lap_time = r_lap_time;
  assign o_lap_cnt  = r_lap_cnt;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control and display sequencing.
// Turns start/stop/split pulses into the counter enable and clear, keeps the
// lap capture, and picks live or frozen lap time for the display.
// Optional macro STOPWATCH_HR_PAGE_EN adds a page bit selecting hr:min digits.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned LAP_MAX = 9  // valid range 1..15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_split,
  input  logic              i_page,
  input  logic              i_tick_1hz,
  input  logic [TIME_W-1:0] i_live_time,
  output logic              o_running,
  output logic              o_clr,
  output logic [DISP_W-1:0] o_disp_value,
  output logic [LAP_W-1:0]  o_lap_cnt,
  output logic              o_blink
);

  sw_state_e         r_state;
  sw_state_e         w_state_d;
  sw_event_e         w_event;
  logic              w_capture;
  logic              w_clear;

  logic              r_running;
  logic              w_running_d;
  logic              r_clr;
  logic              w_clr_d;
  logic              r_blink;
  logic              w_blink_d;
  logic [DISP_W-1:0] r_disp;
  logic [DISP_W-1:0] w_disp_d;
  logic [TIME_W-1:0] w_src;
  logic [TIME_W-1:0] w_lap_time;

  assign w_event = pick_event(i_stop, i_start, i_split);

  split_latch #(
    .LAP_MAX (LAP_MAX)
  ) u_split_latch (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_capture  (w_capture),
    .i_clear    (w_clear),
    .i_time     (i_live_time),
    .o_lap_time (w_lap_time),
    .o_lap_cnt  (o_lap_cnt)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state decode plus lap capture/clear strobes
  always_comb begin
    w_state_d = r_state;
    w_capture = 1'b0;
    w_clear   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_event == EvStart) begin
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (w_event == EvStop) begin
          w_state_d = StPaused;
        end else if (w_event == EvSplit) begin
          w_state_d = StSplit;
          w_capture = 1'b1;
        end
      end
      StSplit: begin
        if (w_event == EvStop) begin
          w_state_d = StPaused;
        end else if (w_event == EvSplit) begin
          w_state_d = StRun;
        end
      end
      StPaused: begin
        if (w_event == EvStart) begin
          w_state_d = StRun;
        end else if (w_event == EvSplit) begin
          w_state_d = StIdle;
          w_clear   = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output next-values, all keyed off the state being entered
  always_comb begin
    w_running_d = (w_state_d == StRun) || (w_state_d == StSplit);
    w_clr_d     = w_clear;
    w_blink_d   = 1'b0;
    if ((r_state == StPaused) && (w_state_d == StPaused)) begin
      w_blink_d = r_blink ^ i_tick_1hz;
    end
    // On the capture edge the lap register is still stale, so show the
    // digits being captured directly.
    w_src = i_live_time;
    if ((w_state_d == StSplit) && !w_capture) begin
      w_src = w_lap_time;
    end
  end

`ifdef STOPWATCH_HR_PAGE_EN
  logic r_page;
  logic w_page_d;

  assign w_page_d = r_page ^ i_page;

  // Page bit survives clr; only reset returns it to min:sec
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_page <= 1'b0;
    end else begin
      r_page <= w_page_d;
    end
  end

  assign w_disp_d = w_page_d ? w_src[HHMM_LSB +: DISP_W] : w_src[MMSS_LSB +: DISP_W];
`else
  logic w_unused_bits;

  assign w_unused_bits = ^{i_page, w_src[TIME_W-1:DISP_W]};
  assign w_disp_d      = w_src[MMSS_LSB +: DISP_W];
`endif

  // Registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_running <= 1'b0;
      r_clr     <= 1'b0;
      r_blink   <= 1'b0;
      r_disp    <= '0;
    end else begin
      r_running <= w_running_d;
      r_clr     <= w_clr_d;
      r_blink   <= w_blink_d;
      r_disp    <= w_disp_d;
    end
  end

  assign o_running    = r_running;
  assign o_clr        = r_clr;
  assign o_blink      = r_blink;
  assign o_disp_value = r_disp;

endmodule
